seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised multi-cycle ALU for the next 8CPU generation; replaces the purely combinational 8-bit ALU. It adds carry/borrow arithmetic, shifts, a full flag set and an iterative shift-add multiplier behind a valid/ready handshake, so the control unit can stall on long operations. It sits between the control unit's register file read ports and its write-back/flag register.

## Interface
- WIDTH, 8, operand/result width; power of two, >= 4
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request (high only in IDLE)
- op  in  4  operation code, captured on accept
- a  in  WIDTH  operand A, captured on accept
- b  in  WIDTH  operand B, captured on accept
- flags_in  in  8  current CPU flag register, captured on accept
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  consumer takes the result
- c  out  WIDTH  result (low half for MUL)
- c_hi  out  WIDTH  high half of the MUL product; 0 for all other ops
- flags_out  out  8  updated flags
- err  out  1  illegal or disabled opcode; valid with out_valid

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(a), 6 CMP, 7 SHL, 8 SHR, 9 ASR, A ADC (a+b+C), B SBB (a-b-C), C MUL (unsigned), D-F illegal.
- Flag bits: 0 EQ, 1 GRT (unsigned a>b), 2 Z, 3 C, 4 N, 5 V; bits 7:6 pass through from flags_in.
- EQ/GRT are written only by CMP. Every other op passes them through from flags_in.
- ADD/ADC: C = carry out; V = signed overflow.
- SUB/SBB/CMP: C = borrow (unsigned a < b, plus borrow-in for SBB); V = signed overflow.
- CMP: c = a; Z/N/C/V are set as for SUB.
- Logic ops and NOT: Z and N from the result; C and V cleared.
- Shifts: the amount is b[SHW-1:0]. C = last bit shifted out, or 0 for a shift amount of 0. V is cleared.
- MUL: 2·WIDTH-bit product is {c_hi, c}. Z = full product == 0. C = V = (c_hi != 0). N = c[WIDTH-1].
- Illegal op: c = a, c_hi = 0, flags_out = flags_in, err = 1.
- State machine:
  - IDLE: on in_valid, capture op/a/b/flags_in. Go to MUL if op = C and the multiplier is enabled, else compute and go to DONE.
  - MUL: one shift-add step per cycle. A counter runs 0..WIDTH-1, then go to DONE.
  - DONE: out_valid = 1; on out_ready go to IDLE.
- Outputs are registered and held stable in DONE until the handshake completes.

## Timing
- Reset: state IDLE, out_valid 0, c 0, c_hi 0, flags_out 0, err 0, mul counter 0. in_ready is 0 while rst is high and 1 from the first cycle after.
- Single-cycle ops: accepted at edge N, out_valid high from edge N+1.
- MUL latency: accepted at edge N, out_valid high from edge N+1+WIDTH (9 cycles for WIDTH = 8).
- Throughput: at most one request per two cycles. in_ready is low in DONE, even in the cycle where out_ready is high.
- in_valid without in_ready is ignored; the requester must hold it.
- rst during MUL or DONE aborts to IDLE next edge. The pending result is discarded and out_valid drops.

## Configuration
- SEQ_ALU_MUL_EN defined: MUL implemented as above, including the counter and the 2·WIDTH-bit accumulator.
- SEQ_ALU_MUL_EN undefined: no multiplier logic. Opcode C is treated as illegal (single-cycle, err = 1, c = a, c_hi = 0, flags passed through).

## Test plan
- Carry and overflow on ADD (WIDTH=8): ADD a=0x7F b=0x01 flags_in=0xC0 -> c=0x80, flags_out=0xF0 (N, V, bits 7:6), err=0, out_valid one cycle after accept.
- Borrow on SBB: SBB a=0x00 b=0x00 flags_in=0x08 -> c=0xFF, flags_out=0x18 (C, N).
- CMP: CMP a=0x05 b=0x03 -> c=0x05, flags_out=0x02 (GRT only).
- CMP equal: CMP a=0x05 b=0x05 -> flags_out=0x05 (EQ, Z).
- Multiply (SEQ_ALU_MUL_EN defined): MUL a=0xFF b=0xFF -> {c_hi,c}=0xFE01, flags_out C=V=1, out_valid exactly 9 cycles after accept. Hold out_ready low 3 cycles -> outputs stable and in_ready=0 throughout.
- Multiplier compiled out (SEQ_ALU_MUL_EN undefined): opcode C -> err=1, c=a, latency 1.
- Shift and illegal op: SHR a=0x81 b=0x01 -> c=0x40, C=1. Opcode E -> err=1, flags_out=flags_in.
- Reset abort: assert rst mid-MUL at cycle 4 -> out_valid stays 0, in_ready=1 the cycle after rst falls. A following ADD 2+3 -> c=0x05.

Source files
------------

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bus of the sequential ALU.
// The master issues operations and takes results; the slave is the ALU.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [7:0]       flags_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] c_hi;
  logic [7:0]       flags_out;
  logic             err;

  modport master (
    output in_valid, op, a, b, flags_in, out_ready,
    input  in_ready, out_valid, c, c_hi, flags_out, err
  );

  modport slave (
    input  in_valid, op, a, b, flags_in, out_ready,
    output in_ready, out_valid, c, c_hi, flags_out, err
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshake for the 8CPU control unit.
// Single-cycle ops finish straight from IDLE; MUL runs an iterative shift-add.
// Optional feature macro: SEQ_ALU_MUL_EN (defined = multiplier built in,
// undefined = opcode C is reported as illegal).
// Flag layout: 0 EQ, 1 GRT, 2 Z, 3 C, 4 N, 5 V, 7:6 passed through.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_CMP = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_ASR = 4'h9;
  localparam logic [3:0] OP_ADC = 4'hA;
  localparam logic [3:0] OP_SBB = 4'hB;
`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'hC;
`endif

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_hi_q;
  logic [7:0]       flags_q;
  logic             err_q;

  logic             start_mul;
  logic             mul_last;

  logic [WIDTH-1:0] alu_c;
  logic [7:0]       alu_flags;
  logic             alu_err;
  logic [WIDTH-1:0] zn_src;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;
  logic [WIDTH:0]   asr_w;
  logic [SHW-1:0]   amt;
  logic             cin;

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.c         = res_q;
  assign bus.c_hi      = res_hi_q;
  assign bus.flags_out = flags_q;
  assign bus.err       = err_q;

`ifdef SEQ_ALU_MUL_EN
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   b_r;
  logic [7:0]         flags_r;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_next;
  logic [7:0]         mul_flags;
  logic               hi_nz;

  assign start_mul = (bus.op == OP_MUL);
  assign mul_last  = (state == MUL) && (cnt == SHW'(WIDTH - 1));

  // One shift-add step: add the multiplicand into the high half when the
  // current multiplier bit (acc LSB) is set, then shift the whole accumulator right.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_r} : '0);
    prod_next = {mul_sum, acc[WIDTH-1:1]};
    hi_nz     = (prod_next[2*WIDTH-1:WIDTH] != '0);
    mul_flags = {flags_r[7:6], hi_nz, prod_next[WIDTH-1], hi_nz,
                 (prod_next == '0), flags_r[1:0]};
  end
`else
  assign start_mul = 1'b0;
  assign mul_last  = 1'b0;
`endif

  // Single-cycle result and flags computed directly from the bus operands.
  always_comb begin
    cin       = bus.flags_in[3];
    amt       = bus.b[SHW-1:0];
    add_sum   = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, (bus.op == OP_ADC) && cin};
    sub_diff  = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, (bus.op == OP_SBB) && cin};
    shl_w     = {1'b0, bus.a} << amt;
    shr_w     = {bus.a, 1'b0} >> amt;
    asr_w     = $signed({bus.a, 1'b0}) >>> amt;
    alu_c     = bus.a;
    alu_flags = bus.flags_in;
    alu_err   = 1'b0;
    zn_src    = bus.a;
    case (bus.op)
      OP_ADD, OP_ADC: begin
        alu_c        = add_sum[WIDTH-1:0];
        zn_src       = add_sum[WIDTH-1:0];
        alu_flags[3] = add_sum[WIDTH];
        alu_flags[5] = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                       (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        alu_c        = (bus.op == OP_CMP) ? bus.a : sub_diff[WIDTH-1:0];
        zn_src       = sub_diff[WIDTH-1:0];
        alu_flags[3] = sub_diff[WIDTH];
        alu_flags[5] = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                       (sub_diff[WIDTH-1] != bus.a[WIDTH-1]);
        if (bus.op == OP_CMP) begin
          alu_flags[0] = (bus.a == bus.b);
          alu_flags[1] = (bus.a > bus.b);
        end
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT: begin
        case (bus.op)
          OP_AND:  alu_c = bus.a & bus.b;
          OP_OR:   alu_c = bus.a | bus.b;
          OP_XOR:  alu_c = bus.a ^ bus.b;
          default: alu_c = ~bus.a;
        endcase
        zn_src       = alu_c;
        alu_flags[3] = 1'b0;
        alu_flags[5] = 1'b0;
      end
      OP_SHL: begin
        alu_c        = shl_w[WIDTH-1:0];
        zn_src       = shl_w[WIDTH-1:0];
        alu_flags[3] = shl_w[WIDTH];
        alu_flags[5] = 1'b0;
      end
      OP_SHR: begin
        alu_c        = shr_w[WIDTH:1];
        zn_src       = shr_w[WIDTH:1];
        alu_flags[3] = shr_w[0];
        alu_flags[5] = 1'b0;
      end
      OP_ASR: begin
        alu_c        = asr_w[WIDTH:1];
        zn_src       = asr_w[WIDTH:1];
        alu_flags[3] = asr_w[0];
        alu_flags[5] = 1'b0;
      end
      default: begin
        alu_err = 1'b1;
      end
    endcase
    if (!alu_err) begin
      alu_flags[2] = (zn_src == '0);
      alu_flags[4] = zn_src[WIDTH-1];
    end
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, iterate in MUL, hold result in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = start_mul ? MUL : DONE;
        end
      end
      MUL: begin
        if (mul_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result registers, loaded on completion and held stable through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q    <= '0;
      res_hi_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      cnt      <= '0;
      acc      <= '0;
      b_r      <= '0;
      flags_r  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
`ifdef SEQ_ALU_MUL_EN
            if (start_mul) begin
              acc     <= {{WIDTH{1'b0}}, bus.a};
              b_r     <= bus.b;
              flags_r <= bus.flags_in;
              cnt     <= '0;
            end else begin
              res_q    <= alu_c;
              res_hi_q <= '0;
              flags_q  <= alu_flags;
              err_q    <= alu_err;
            end
`else
            res_q    <= alu_c;
            res_hi_q <= '0;
            flags_q  <= alu_flags;
            err_q    <= alu_err;
`endif
          end
        end
`ifdef SEQ_ALU_MUL_EN
        MUL: begin
          acc <= prod_next;
          cnt <= cnt + 1'b1;
          if (mul_last) begin
            res_q    <= prod_next[WIDTH-1:0];
            res_hi_q <= prod_next[2*WIDTH-1:WIDTH];
            flags_q  <= mul_flags;
            err_q    <= 1'b0;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu (WIDTH = 8).
// Covers both builds; multiplier vectors depend on SEQ_ALU_MUL_EN.
module tb_seq_alu;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_alu_if #(.WIDTH(8)) bus ();

  seq_alu #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the bench itself gets stuck.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Wait for in_ready, present one request, and count edges (accept edge
  // included) until out_valid is seen.
  task automatic applyStimulus(input logic [3:0] op_v, input logic [7:0] a_v,
                               input logic [7:0] b_v, input logic [7:0] f_v,
                               output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) checkOutput("ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.op       = op_v;
    bus.a        = a_v;
    bus.b        = b_v;
    bus.flags_in = f_v;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Complete the output handshake; in_ready must stay low during it.
  task automatic finishResult(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    checkOutput({tag, "_rdy_done"}, 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [3:0] op_v,
                       input logic [7:0] a_v, input logic [7:0] b_v,
                       input logic [7:0] f_v, input logic [7:0] exp_c,
                       input logic [7:0] exp_hi, input logic [7:0] exp_f,
                       input logic exp_err, input int exp_lat);
    int lat;
    applyStimulus(op_v, a_v, b_v, f_v, lat);
    checkOutput({tag, "_lat"},   32'(lat),           32'(exp_lat));
    checkOutput({tag, "_c"},     32'(bus.c),         32'(exp_c));
    checkOutput({tag, "_chi"},   32'(bus.c_hi),      32'(exp_hi));
    checkOutput({tag, "_flags"}, 32'(bus.flags_out), 32'(exp_f));
    checkOutput({tag, "_err"},   32'(bus.err),       32'(exp_err));
    finishResult(tag);
  endtask

  initial begin
    int lat;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = 4'h0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.flags_in  = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_c",         32'(bus.c),         32'd0);
    checkOutput("rst_chi",       32'(bus.c_hi),      32'd0);
    checkOutput("rst_flags",     32'(bus.flags_out), 32'd0);
    checkOutput("rst_err",       32'(bus.err),       32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(bus.in_ready), 32'd1);

    //      tag        op     a      b      fin    c      hi     flags  err lat
    runOp("add_ovf",   4'h0, 8'h7F, 8'h01, 8'hC0, 8'h80, 8'h00, 8'hF0, 0, 1);
    runOp("add_cy",    4'h0, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 0, 1);
    runOp("sub_bw",    4'h1, 8'h03, 8'h05, 8'h00, 8'hFE, 8'h00, 8'h18, 0, 1);
    runOp("sbb",       4'hB, 8'h00, 8'h00, 8'h08, 8'hFF, 8'h00, 8'h18, 0, 1);
    runOp("adc",       4'hA, 8'h7F, 8'h00, 8'h08, 8'h80, 8'h00, 8'h30, 0, 1);
    runOp("cmp_gt",    4'h6, 8'h05, 8'h03, 8'h00, 8'h05, 8'h00, 8'h02, 0, 1);
    runOp("cmp_eq",    4'h6, 8'h05, 8'h05, 8'h00, 8'h05, 8'h00, 8'h05, 0, 1);
    runOp("and",       4'h2, 8'hF0, 8'h3C, 8'h3B, 8'h30, 8'h00, 8'h03, 0, 1);
    runOp("or_zero",   4'h3, 8'h00, 8'h00, 8'hC8, 8'h00, 8'h00, 8'hC4, 0, 1);
    runOp("xor",       4'h4, 8'h55, 8'h55, 8'h00, 8'h00, 8'h00, 8'h04, 0, 1);
    runOp("not",       4'h5, 8'h0F, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h10, 0, 1);
    runOp("shr",       4'h8, 8'h81, 8'h01, 8'h00, 8'h40, 8'h00, 8'h08, 0, 1);
    runOp("shr_zero",  4'h8, 8'h80, 8'h00, 8'h00, 8'h80, 8'h00, 8'h10, 0, 1);
    runOp("shl",       4'h7, 8'h81, 8'h01, 8'h00, 8'h02, 8'h00, 8'h08, 0, 1);
    runOp("shl_amt",   4'h7, 8'h40, 8'h09, 8'h00, 8'h80, 8'h00, 8'h10, 0, 1);
    runOp("asr",       4'h9, 8'h81, 8'h02, 8'h00, 8'hE0, 8'h00, 8'h10, 0, 1);
    runOp("illegal_e", 4'hE, 8'h12, 8'h34, 8'h5A, 8'h12, 8'h00, 8'h5A, 1, 1);

`ifdef SEQ_ALU_MUL_EN
    // Full-scale multiply, then hold the result for three cycles.
    applyStimulus(4'hC, 8'hFF, 8'hFF, 8'h00, lat);
    checkOutput("mul_lat",   32'(lat),           32'd9);
    checkOutput("mul_c",     32'(bus.c),         32'h01);
    checkOutput("mul_chi",   32'(bus.c_hi),      32'hFE);
    checkOutput("mul_flags", 32'(bus.flags_out), 32'h28);
    checkOutput("mul_err",   32'(bus.err),       32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("mul_hold_c",     32'(bus.c),         32'h01);
      checkOutput("mul_hold_chi",   32'(bus.c_hi),      32'hFE);
      checkOutput("mul_hold_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("mul_hold_rdy",   32'(bus.in_ready),  32'd0);
    end
    finishResult("mul");
    runOp("mul_pass",  4'hC, 8'h10, 8'h10, 8'hC3, 8'h00, 8'h01, 8'hEB, 0, 9);
    runOp("mul_zero",  4'hC, 8'h00, 8'h37, 8'h00, 8'h00, 8'h00, 8'h04, 0, 9);

    // Reset in the fourth cycle of a multiply discards it.
    @(negedge clk);
    bus.op       = 4'hC;
    bus.a        = 8'h0F;
    bus.b        = 8'h0F;
    bus.flags_in = 8'h00;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_rdy_in_rst", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("abort_valid", 32'(bus.out_valid), 32'd0);
    end
`else
    runOp("mul_off",   4'hC, 8'h33, 8'h44, 8'h0F, 8'h33, 8'h00, 8'h0F, 1, 1);
`endif
    runOp("add_after", 4'h0, 8'h02, 8'h03, 8'h00, 8'h05, 8'h00, 8'h00, 0, 1);

    // Reset while a result is pending in DONE drops it.
    applyStimulus(4'h3, 8'hA5, 8'h00, 8'h00, lat);
    checkOutput("done_rst_pre", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("done_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("done_rst_c",     32'(bus.c),         32'd0);
    @(negedge clk);
    checkOutput("done_rst_ready", 32'(bus.in_ready),  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
